// File: rtl/id_operand_stage_if.sv
// id_operand_stage_if -- handshake and datapath bundle for the decode/operand stage.
//   Upstream side : in_valid/in_ready/instr and the register write-back port (wb_*).
//   Downstream side: out_valid/out_ready and the registered ALU operands/control
//                    (alu_operation, input_data1, input_data2, dest_reg, reg_write, illegal).
//   modport slave  : the stage itself.
//   modport master : whatever drives instructions/write-back and consumes the operands.
interface id_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic              wb_en;
  logic [IDX_W-1:0]  wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        alu_operation;
  logic [DATA_W-1:0] input_data1;
  logic [DATA_W-1:0] input_data2;
  logic [IDX_W-1:0]  dest_reg;
  logic              reg_write;
  logic              illegal;

  modport slave (
    input  in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, alu_operation, input_data1, input_data2,
           dest_reg, reg_write, illegal
  );

  modport master (
    output in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, alu_operation, input_data1, input_data2,
           dest_reg, reg_write, illegal
  );
endinterface

// File: rtl/id_operand_stage.sv
// id_operand_stage -- MIPS decode/operand stage feeding the ALU.
//   Decodes one instruction per in_valid/in_ready handshake, reads rs/rt from a
//   REG_CNT x DATA_W register file (one write-back port, same-cycle bypass, r0 = 0),
//   picks rt or the extended immediate for operand 2 and derives the 3-bit ALU op.
//   Results sit in a one-entry valid/ready output register.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears register file and output register)
//   bus   : id_operand_stage_if.slave (instruction, write-back and operand signals)
// Build option:
//   ILLEGAL_TRAP_EN defined   -> illegal instructions are consumed but not forwarded,
//                                and a sticky illegal flag is raised.
//   ILLEGAL_TRAP_EN undefined -> illegal instructions are forwarded as op 3'b011
//                                with no register write; illegal stays 0.
module id_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input logic             clk,
  input logic             rst_n,
  id_operand_stage_if.slave bus
);
  logic [REG_CNT-1:0][DATA_W-1:0] r_rf;

  logic [5:0]        w_opc, w_fn;
  logic [4:0]        w_rs, w_rt, w_rd;
  logic [15:0]       w_imm;
  logic [DATA_W-1:0] w_rs_val, w_rt_val;
  logic [2:0]        w_op, w_op_out;
  logic [DATA_W-1:0] w_d2;
  logic [4:0]        w_dest;
  logic              w_wr, w_ill;
  logic              w_cap, w_fwd;

  logic              r_vld;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_d1, r_d2;
  logic [4:0]        r_dest;
  logic              r_wr;

  assign w_opc = bus.instr[31:26];
  assign w_rs  = bus.instr[25:21];
  assign w_rt  = bus.instr[20:16];
  assign w_rd  = bus.instr[15:11];
  assign w_imm = bus.instr[15:0];
  assign w_fn  = bus.instr[5:0];

  // Register file; entry 0 is never written so it stays at its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rf <= '0;
    else if (bus.wb_en && bus.wb_addr != '0)
      r_rf[bus.wb_addr] <= bus.wb_data;
  end

  // Write-through: a write landing this cycle is visible to the instruction captured now.
  assign w_rs_val = (w_rs == '0) ? '0 :
                    (bus.wb_en && bus.wb_addr == w_rs) ? bus.wb_data : r_rf[w_rs];
  assign w_rt_val = (w_rt == '0) ? '0 :
                    (bus.wb_en && bus.wb_addr == w_rt) ? bus.wb_data : r_rf[w_rt];

  always_comb begin
    w_op   = 3'b000;
    w_d2   = w_rt_val;
    w_dest = '0;
    w_wr   = 1'b0;
    w_ill  = 1'b0;
    case (w_opc)
      6'h00: begin
        w_dest = w_rd;
        w_wr   = 1'b1;
        case (w_fn)
          6'h20:   w_op = 3'b010;
          6'h22:   w_op = 3'b110;
          6'h24:   w_op = 3'b000;
          6'h25:   w_op = 3'b001;
          6'h2A:   w_op = 3'b111;
          default: begin
            w_ill  = 1'b1;
            w_dest = '0;
            w_wr   = 1'b0;
          end
        endcase
      end
      6'h08, 6'h23: begin
        w_op   = 3'b010;
        w_d2   = {{(DATA_W-16){w_imm[15]}}, w_imm};
        w_dest = w_rt;
        w_wr   = 1'b1;
      end
      6'h0D: begin
        w_op   = 3'b001;
        w_d2   = {{(DATA_W-16){1'b0}}, w_imm};
        w_dest = w_rt;
        w_wr   = 1'b1;
      end
      6'h2B: begin
        w_op = 3'b010;
        w_d2 = {{(DATA_W-16){w_imm[15]}}, w_imm};
      end
      6'h04:   w_op = 3'b110;
      default: w_ill = 1'b1;
    endcase
  end

  assign bus.in_ready = !r_vld || bus.out_ready;
  assign w_cap        = bus.in_valid && bus.in_ready;

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;

  // Illegal words complete the handshake but never reach the output register.
  assign w_fwd    = w_cap && !w_ill;
  assign w_op_out = w_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_illegal <= 1'b0;
    else if (w_cap && w_ill)
      r_illegal <= 1'b1;
  end

  assign bus.illegal = r_illegal;
`else
  // Illegal words pass through as a recognisable no-write op.
  assign w_fwd       = w_cap;
  assign w_op_out    = w_ill ? 3'b011 : w_op;
  assign bus.illegal = 1'b0;
`endif

  // One-entry output register: loads on forward, empties on drain without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_op   <= 3'b000;
      r_d1   <= '0;
      r_d2   <= '0;
      r_dest <= '0;
      r_wr   <= 1'b0;
    end else if (w_fwd) begin
      r_vld  <= 1'b1;
      r_op   <= w_op_out;
      r_d1   <= w_rs_val;
      r_d2   <= w_d2;
      r_dest <= w_dest;
      r_wr   <= w_wr;
    end else if (bus.out_ready) begin
      r_vld  <= 1'b0;
    end
  end

  assign bus.out_valid     = r_vld;
  assign bus.alu_operation = r_op;
  assign bus.input_data1   = r_d1;
  assign bus.input_data2   = r_d2;
  assign bus.dest_reg      = r_dest;
  assign bus.reg_write     = r_wr;
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage -- self-checking bench for id_operand_stage.
//   Directed vector table, hand-written backpressure/reset/illegal sequences,
//   then randomized traffic against a transaction-level reference model.
module tb_id_operand_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_operand_stage_if #(.DATA_W(32), .IDX_W(5)) bus ();
  id_operand_stage #(.DATA_W(32), .REG_CNT(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  dest;
    logic        wr;
  } out_t;

  typedef struct {
    logic [31:0] ins;
    logic        wb_en;
    logic [4:0]  wa;
    logic [31:0] wd;
    out_t        exp;
  } vec_t;

  out_t act;
  assign act = {bus.alu_operation, bus.input_data1, bus.input_data2, bus.dest_reg, bus.reg_write};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [72:0] a, input logic [72:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] mrf [32];
  out_t        q [$];
  logic        sticky;
  logic [5:0]  fn_tbl [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  function automatic logic [31:0] mread(input logic [4:0] idx, input logic wen,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 0) return 32'd0;
    if (wen && wa == idx) return wd;
    return mrf[idx];
  endfunction

  function automatic out_t model(input logic [31:0] ins, input logic [31:0] a, b,
                                 output logic ill);
    out_t e;
    logic [31:0] sx, zx;
    sx = 32'($signed(ins[15:0]));
    zx = 32'(ins[15:0]);
    e = '{op: 3'b011, d1: a, d2: b, dest: 5'd0, wr: 1'b0};
    ill = 1'b0;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20: e.op = 3'b010;
          6'h22: e.op = 3'b110;
          6'h24: e.op = 3'b000;
          6'h25: e.op = 3'b001;
          6'h2A: e.op = 3'b111;
          default: ill = 1'b1;
        endcase
        if (!ill) begin e.dest = ins[15:11]; e.wr = 1'b1; end
      end
      6'h08: e = '{3'b010, a, sx, ins[20:16], 1'b1};
      6'h23: e = '{3'b010, a, sx, ins[20:16], 1'b1};
      6'h0D: e = '{3'b001, a, zx, ins[20:16], 1'b1};
      6'h2B: e = '{3'b010, a, sx, 5'd0, 1'b0};
      6'h04: e = '{3'b110, a, b, 5'd0, 1'b0};
      default: ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    int k;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); imm = 16'($urandom);
    k = $urandom_range(0, 12);
    case (k)
      0, 1, 2, 3, 4: return rtype(rs, rt, rd, fn_tbl[k]);
      5:  return itype(6'h08, rs, rt, imm);
      6:  return itype(6'h0D, rs, rt, imm);
      7:  return itype(6'h23, rs, rt, imm);
      8:  return itype(6'h2B, rs, rt, imm);
      9:  return itype(6'h04, rs, rt, imm);
      10: return rtype(rs, rt, rd, 6'($urandom));
      11: return $urandom;
      default: return rtype(rs, rt, rd, 6'h3F);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [12];
  out_t ea, eb;
  logic [31:0] ia, ib;

  initial begin
    bus.in_valid = 1'b0; bus.instr = '0; bus.wb_en = 1'b0;
    bus.wb_addr = '0; bus.wb_data = '0; bus.out_ready = 1'b0;

    tbl[0]  = '{rtype(1, 2, 3, 6'h24),       0, 0, 0,  '{3'b000, 32'd3, 32'd4, 5'd3, 1'b1}};
    tbl[1]  = '{itype(6'h08, 1, 5, 16'hFFFE), 0, 0, 0,  '{3'b010, 32'd3, 32'hFFFF_FFFE, 5'd5, 1'b1}};
    tbl[2]  = '{itype(6'h0D, 1, 5, 16'h8000), 0, 0, 0,  '{3'b001, 32'd3, 32'h0000_8000, 5'd5, 1'b1}};
    tbl[3]  = '{rtype(6, 6, 7, 6'h22),       1, 6, 5,  '{3'b110, 32'd5, 32'd5, 5'd7, 1'b1}};
    tbl[4]  = '{rtype(0, 1, 8, 6'h2A),       1, 0, 9,  '{3'b111, 32'd0, 32'd3, 5'd8, 1'b1}};
    tbl[5]  = '{itype(6'h23, 2, 9, 16'h0008), 0, 0, 0,  '{3'b010, 32'd4, 32'd8, 5'd9, 1'b1}};
    tbl[6]  = '{itype(6'h2B, 1, 2, 16'hFFFC), 0, 0, 0,  '{3'b010, 32'd3, 32'hFFFF_FFFC, 5'd0, 1'b0}};
    tbl[7]  = '{itype(6'h04, 1, 2, 16'h0010), 0, 0, 0,  '{3'b110, 32'd3, 32'd4, 5'd0, 1'b0}};
    tbl[8]  = '{rtype(1, 2, 10, 6'h20),      0, 0, 0,  '{3'b010, 32'd3, 32'd4, 5'd10, 1'b1}};
    tbl[9]  = '{rtype(1, 2, 11, 6'h25),      0, 0, 0,  '{3'b001, 32'd3, 32'd4, 5'd11, 1'b1}};
    tbl[10] = '{itype(6'h08, 2, 12, 16'h7FFF), 0, 0, 0, '{3'b010, 32'd4, 32'h0000_7FFF, 5'd12, 1'b1}};
    tbl[11] = '{rtype(6, 1, 12, 6'h20),      0, 0, 0,  '{3'b010, 32'd5, 32'd3, 5'd12, 1'b1}};

    // reset state
    #12;
    chk("rst_outs", act, '0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_illegal", bus.illegal, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    tick();
    rst_n = 1'b1;

    // preload r1=3, r2=4
    bus.wb_en = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'd3; tick();
    bus.wb_addr = 5'd2; bus.wb_data = 32'd4; tick();
    bus.wb_en = 1'b0;

    // directed vectors
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1; bus.instr = tbl[i].ins; bus.out_ready = 1'b1;
      bus.wb_en = tbl[i].wb_en; bus.wb_addr = tbl[i].wa; bus.wb_data = tbl[i].wd;
      tick();
      bus.in_valid = 1'b0; bus.wb_en = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
      chk($sformatf("vec%0d_outs", i), act, tbl[i].exp);
      tick();
      @(negedge clk);
      chk($sformatf("vec%0d_drain", i), bus.out_valid, 1'b0);
      tick();
    end

    // illegal funct and illegal opcode
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      bus.instr = (i == 0) ? rtype(1, 2, 3, 6'h3F) : itype(6'h3F, 1, 2, 16'h1234);
      @(negedge clk);
      chk($sformatf("ill%0d_in_ready", i), bus.in_ready, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
`ifdef ILLEGAL_TRAP_EN
      chk($sformatf("ill%0d_no_valid", i), bus.out_valid, 1'b0);
      chk($sformatf("ill%0d_flag", i), bus.illegal, 1'b1);
      tick(); tick();
      @(negedge clk);
      chk($sformatf("ill%0d_sticky", i), bus.illegal, 1'b1);
`else
      chk($sformatf("ill%0d_valid", i), bus.out_valid, 1'b1);
      chk($sformatf("ill%0d_outs", i), act, out_t'({3'b011, 32'd3, 32'd4, 5'd0, 1'b0}));
      chk($sformatf("ill%0d_flag", i), bus.illegal, 1'b0);
`endif
      tick();
    end

    // backpressure: A held while B waits, then B delivered exactly once
    ia = rtype(1, 2, 10, 6'h20);       ea = '{3'b010, 32'd3, 32'd4, 5'd10, 1'b1};
    ib = itype(6'h0D, 2, 11, 16'h00F0); eb = '{3'b001, 32'd4, 32'h0000_00F0, 5'd11, 1'b1};
    tick();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.instr = ia;
    tick();
    bus.instr = ib;
    @(negedge clk);
    chk("bp_in_ready_low", bus.in_ready, 1'b0);
    chk("bp_hold_a0", act, ea);
    tick();
    @(negedge clk);
    chk("bp_hold_a1", act, ea);
    chk("bp_valid_a", bus.out_valid, 1'b1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_valid_b", bus.out_valid, 1'b1);
    chk("bp_outs_b", act, eb);
    tick();
    @(negedge clk);
    chk("bp_hold_b", act, eb);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_no_dup", bus.out_valid, 1'b0);

    // reset during a stall drops the held word immediately
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.instr = ia;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("stall_valid", bus.out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", bus.out_valid, 1'b0);
    chk("rst_mid_outs", act, '0);
    chk("rst_mid_illegal", bus.illegal, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.instr = rtype(1, 2, 3, 6'h20);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rf_cleared", act, out_t'({3'b010, 32'd0, 32'd0, 5'd3, 1'b1}));
    tick();

    // randomized traffic vs reference model (register file is all zero here)
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    sticky = 1'b0;
    for (int i = 0; i < 800; i++) begin
      logic rdy, ill;
      out_t e;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.wb_en     = 1'($urandom_range(0, 1));
      bus.wb_addr   = 5'($urandom);
      bus.wb_data   = $urandom;
      bus.instr     = rand_instr();
      @(negedge clk);
      rdy = (q.size() == 0) || bus.out_ready;
      chk("rnd_out_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) chk("rnd_outs", act, q[0]);
      chk("rnd_in_ready", bus.in_ready, rdy);
      chk("rnd_illegal", bus.illegal, sticky);
      if (bus.out_ready && q.size() != 0) void'(q.pop_front());
      if (bus.in_valid && rdy) begin
        e = model(bus.instr,
                  mread(bus.instr[25:21], bus.wb_en, bus.wb_addr, bus.wb_data),
                  mread(bus.instr[20:16], bus.wb_en, bus.wb_addr, bus.wb_data), ill);
`ifdef ILLEGAL_TRAP_EN
        if (ill) sticky = 1'b1;
        else q.push_back(e);
`else
        q.push_back(e);
`endif
      end
      if (bus.wb_en && bus.wb_addr != 0) mrf[bus.wb_addr] = bus.wb_data;
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
